// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared types for the multi-cycle ALU.
//   opcode_e  - 4-bit operation code carried on ctrl_in
//   state_e   - control FSM states
//   FLAG_*    - bit positions inside flags_out
package alu_mc_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_NOT = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9,
        OP_ASR = 4'd10,
        OP_ROL = 4'd11,
        OP_ROR = 4'd12
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_e;

    localparam int FLAG_C  = 0;
    localparam int FLAG_V  = 1;
    localparam int FLAG_Z  = 2;
    localparam int FLAG_N  = 3;
    localparam int FLAG_P  = 4;
    localparam int FLAG_DZ = 5;

endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: iterative unsigned shift-add multiplier / restoring divider.
//   clk_in, rst_n_in : clock, async active-low reset
//   i_start          : load operands and begin WIDTH iterations
//   i_is_div         : 1 = divide (a / b), 0 = multiply (a * b)
//   i_a, i_b         : operands, sampled only on i_start
//   o_done           : high during the final iteration cycle
//   o_hi, o_lo       : next-step accumulator / shift register; on o_done
//                      these hold {product hi, lo} or {remainder, quotient}
module alu_mc_iter
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             i_start,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_acc;   // product high half / partial remainder
    logic [WIDTH-1:0] r_sr;    // multiplier / dividend, result shifts in
    logic [WIDTH-1:0] r_opnd;  // multiplicand / divisor
    logic [SHW-1:0]   r_cnt;
    logic             r_busy;
    logic             r_div;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_acc_n;
    logic [WIDTH-1:0] w_sr_n;

    always_comb begin
        w_sum   = {1'b0, r_acc} + (r_sr[0] ? {1'b0, r_opnd} : '0);
        w_shift = {r_acc, r_sr[WIDTH-1]};
        w_trial = w_shift - {1'b0, r_opnd};
        if (r_div) begin
            // Bit WIDTH of the trial difference is the borrow: restore on borrow.
            if (!w_trial[WIDTH]) begin
                w_acc_n = w_trial[WIDTH-1:0];
                w_sr_n  = {r_sr[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_n = w_shift[WIDTH-1:0];
                w_sr_n  = {r_sr[WIDTH-2:0], 1'b0};
            end
        end else begin
            {w_acc_n, w_sr_n} = {w_sum, r_sr[WIDTH-1:1]};
        end
    end

    assign o_done = r_busy && (r_cnt == SHW'(WIDTH - 1));
    assign o_hi   = w_acc_n;
    assign o_lo   = w_sr_n;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_acc  <= '0;
            r_sr   <= '0;
            r_opnd <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_div  <= 1'b0;
        end else if (i_start) begin
            r_acc  <= '0;
            r_sr   <= i_a;
            r_opnd <= i_b;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            r_div  <= i_is_div;
        end else if (r_busy) begin
            r_acc <= w_acc_n;
            r_sr  <= w_sr_n;
            r_cnt <= r_cnt + 1'b1;
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready request and result handshakes.
//   clk_in, rst_n_in          : clock, async active-low reset
//   in_valid_in, in_ready_out : request handshake (ready only when idle)
//   a_in, b_in, ctrl_in       : operands and opcode (b_in low bits = shift)
//   out_valid_out, out_ready_in : result handshake
//   results_out               : result / MUL low half / DIV quotient
//   results_hi_out            : MUL high half / DIV remainder / 0
//   flags_out                 : {DZ, P, N, Z, V, C}
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             in_valid_in,
    output logic             in_ready_out,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [3:0]       ctrl_in,
    output logic             out_valid_out,
    input  logic             out_ready_in,
    output logic [WIDTH-1:0] results_out,
    output logic [WIDTH-1:0] results_hi_out,
    output logic [5:0]       flags_out
);
    localparam int SHW = $clog2(WIDTH);

    state_e           r_state;
    logic             r_ready;
    logic             r_valid;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_hi;
    logic [5:0]       r_flags;
    logic             r_is_div;

    opcode_e          w_op;
    logic             w_accept;
    logic             w_long;
    logic [SHW-1:0]   w_amt;
    logic [SHW-1:0]   w_rot;
    logic [WIDTH:0]   w_asr;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_hi;
    logic             w_c;
    logic             w_v;
    logic             w_dz;
    logic             w_known;
    logic [5:0]       w_flags_sc;
    logic [5:0]       w_flags_it;
    logic             w_it_done;
    logic [WIDTH-1:0] w_it_hi;
    logic [WIDTH-1:0] w_it_lo;

    function automatic logic [5:0] mk_flags(input logic [WIDTH-1:0] res,
                                            input logic c, input logic v,
                                            input logic dz);
        logic [5:0] f;
        f          = '0;
        f[FLAG_C]  = c;
        f[FLAG_V]  = v;
        f[FLAG_Z]  = (res == '0);
        f[FLAG_N]  = res[WIDTH-1];
        f[FLAG_P]  = ^res;
        f[FLAG_DZ] = dz;
        return f;
    endfunction

    assign w_op     = opcode_e'(ctrl_in);
    assign w_accept = in_valid_in && r_ready;
    // Divide by zero bypasses the iterative unit and completes in one cycle.
    assign w_long   = (w_op == OP_MUL) || ((w_op == OP_DIV) && (b_in != '0));
    assign w_amt    = b_in[SHW-1:0];
    assign w_rot    = SHW'(w_amt % WIDTH);
    // Extra low bit catches the last bit shifted out as the carry.
    assign w_asr    = $signed({a_in, 1'b0}) >>> w_amt;

    always_comb begin
        w_res   = '0;
        w_hi    = '0;
        w_c     = 1'b0;
        w_v     = 1'b0;
        w_dz    = 1'b0;
        w_known = 1'b1;
        case (w_op)
            OP_ADD: begin
                {w_c, w_res} = {1'b0, a_in} + {1'b0, b_in};
                w_v = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (w_res[WIDTH-1] != a_in[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = a_in - b_in;
                w_c   = (a_in < b_in);
                w_v   = (a_in[WIDTH-1] != b_in[WIDTH-1]) && (w_res[WIDTH-1] != a_in[WIDTH-1]);
            end
            OP_MUL: ;
            OP_DIV: begin
                w_res = '1;
                w_hi  = a_in;
                w_dz  = 1'b1;
            end
            OP_AND: w_res = a_in & b_in;
            OP_OR:  w_res = a_in | b_in;
            OP_XOR: w_res = a_in ^ b_in;
            OP_NOT: w_res = ~a_in;
            OP_SHL: {w_c, w_res} = {1'b0, a_in} << w_amt;
            OP_SHR: {w_res, w_c} = {a_in, 1'b0} >> w_amt;
            OP_ASR: {w_res, w_c} = w_asr;
            OP_ROL: begin
                w_res = (a_in << w_rot) | (a_in >> (WIDTH - int'(w_rot)));
                w_c   = (w_rot != '0) && w_res[0];
            end
            OP_ROR: begin
                w_res = (a_in >> w_rot) | (a_in << (WIDTH - int'(w_rot)));
                w_c   = (w_rot != '0) && w_res[WIDTH-1];
            end
            default: w_known = 1'b0;
        endcase
    end

    assign w_flags_sc = w_known ? mk_flags(w_res, w_c, w_v, w_dz) : '0;
    assign w_flags_it = mk_flags(w_it_lo, !r_is_div && (w_it_hi != '0), 1'b0, 1'b0);

    alu_mc_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .i_start  (w_accept && w_long),
        .i_is_div (w_op == OP_DIV),
        .i_a      (a_in),
        .i_b      (b_in),
        .o_done   (w_it_done),
        .o_hi     (w_it_hi),
        .o_lo     (w_it_lo)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state  <= ST_IDLE;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_res    <= '0;
            r_hi     <= '0;
            r_flags  <= '0;
            r_is_div <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_ready  <= 1'b0;
                        r_is_div <= (w_op == OP_DIV);
                        if (w_long) begin
                            r_state <= ST_BUSY;
                        end else begin
                            r_state <= ST_DONE;
                            r_valid <= 1'b1;
                            r_res   <= w_res;
                            r_hi    <= w_hi;
                            r_flags <= w_flags_sc;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_it_done) begin
                        r_state <= ST_DONE;
                        r_valid <= 1'b1;
                        r_res   <= w_it_lo;
                        r_hi    <= w_it_hi;
                        r_flags <= w_flags_it;
                    end
                end
                ST_DONE: begin
                    if (out_ready_in) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready_out   = r_ready;
    assign out_valid_out  = r_valid;
    assign results_out    = r_res;
    assign results_hi_out = r_hi;
    assign flags_out      = r_flags;

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [3:0] ctrl = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] res;
    logic [7:0] hi;
    logic [5:0] flags;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] res;
        logic [7:0] hi;
        logic [5:0] flags;
    } exp_t;

    exp_t sb[$];
    int   lat_q[$];

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(8)) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .in_valid_in    (in_valid),
        .in_ready_out   (in_ready),
        .a_in           (a),
        .b_in           (b),
        .ctrl_in        (ctrl),
        .out_valid_out  (out_valid),
        .out_ready_in   (out_ready),
        .results_out    (res),
        .results_hi_out (hi),
        .flags_out      (flags)
    );

    // Reference model: integer arithmetic and bit-at-a-time shifting.
    function automatic exp_t model(input logic [3:0] op, input logic [7:0] ma, input logic [7:0] mb);
        exp_t e;
        int ua, ub, sa, sbv, t, amt;
        logic [7:0] r, h;
        logic c, v, dz;
        ua = int'(ma); ub = int'(mb);
        sa  = (ua > 127) ? ua - 256 : ua;
        sbv = (ub > 127) ? ub - 256 : ub;
        r = '0; h = '0; c = 1'b0; v = 1'b0; dz = 1'b0; t = 0;
        amt = int'(mb[2:0]);
        case (op)
            4'd0: begin t = ua + ub; r = t[7:0]; c = (t > 255); v = (sa + sbv > 127) || (sa + sbv < -128); end
            4'd1: begin t = ua - ub; r = t[7:0]; c = (ua < ub); v = (sa - sbv > 127) || (sa - sbv < -128); end
            4'd2: begin t = ua * ub; r = t[7:0]; h = t[15:8]; c = (h != 8'h00); end
            4'd3: begin
                if (ub == 0) begin r = 8'hFF; h = ma; dz = 1'b1; end
                else begin t = ua / ub; r = t[7:0]; t = ua % ub; h = t[7:0]; end
            end
            4'd4: r = ma & mb;
            4'd5: r = ma | mb;
            4'd6: r = ma ^ mb;
            4'd7: r = ~ma;
            4'd8:  begin r = ma; for (int i = 0; i < amt; i++) begin c = r[7]; r = {r[6:0], 1'b0}; end end
            4'd9:  begin r = ma; for (int i = 0; i < amt; i++) begin c = r[0]; r = {1'b0, r[7:1]}; end end
            4'd10: begin r = ma; for (int i = 0; i < amt; i++) begin c = r[0]; r = {r[7], r[7:1]}; end end
            4'd11: begin r = ma; for (int i = 0; i < amt; i++) begin c = r[7]; r = {r[6:0], r[7]}; end end
            4'd12: begin r = ma; for (int i = 0; i < amt; i++) begin c = r[0]; r = {r[0], r[7:1]}; end end
            default: begin
                e.res = '0; e.hi = '0; e.flags = '0;
                return e;
            end
        endcase
        e.res = r;
        e.hi = h;
        e.flags = {dz, ^r, r[7], (r == 8'h00), v, c};
        return e;
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [7:0] mb);
        if (op == 4'd2 || (op == 4'd3 && mb != 8'h00)) return 9;
        return 1;
    endfunction

    // Drive one request, push its expectation, wait (bounded) for out_valid.
    // lat = clock edges from the accepting edge to out_valid, -1 on timeout.
    task automatic run_op(input logic [3:0] op, input logic [7:0] ra, input logic [7:0] rb,
                          output int lat, output bit rdy_seen);
        int n;
        @(negedge clk);
        in_valid = 1'b1; ctrl = op; a = ra; b = rb;
        sb.push_back(model(op, ra, rb));
        lat_q.push_back(model_lat(op, rb));
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        rdy_seen = 1'b0;
        if (!in_ready) begin
            in_valid = 1'b0;
            lat = -1;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); ctrl = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            rdy_seen |= in_ready;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic handshake;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({out_valid, res, hi, flags} !== 23'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {out_valid, res, hi, flags});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: ready/valid got %b expected 10", {in_ready, out_valid});
        end
    endtask

    // Directed op: scoreboard vector, hard-coded vector and latency.
    task automatic test_directed(input string name, input logic [3:0] op, input logic [7:0] da,
                                 input logic [7:0] db, input exp_t want, input int want_lat);
        int lat, el;
        bit rs;
        exp_t e;
        run_op(op, da, db, lat, rs);
        e = sb.pop_front();
        el = lat_q.pop_front();
        checks++;
        if ({res, hi, flags} !== e) begin
            errors++;
            $display("FAIL %s_sb: got %h expected %h", name, {res, hi, flags}, e);
        end
        checks++;
        if ({res, hi, flags} !== want) begin
            errors++;
            $display("FAIL %s_const: got %h expected %h", name, {res, hi, flags}, want);
        end
        checks++;
        if (lat != want_lat || lat != el) begin
            errors++;
            $display("FAIL %s_latency: got %0d expected %0d", name, lat, want_lat);
        end
        if (op == 4'd2) begin
            checks++;
            if (rs !== 1'b0) begin
                errors++;
                $display("FAIL %s_ready_busy: in_ready seen %b expected 0", name, rs);
            end
        end
        handshake();
    endtask

    task automatic test_ops;
        test_directed("add",  4'd0,  8'hFF, 8'h01, {8'h00, 8'h00, 6'h05}, 1);
        test_directed("sub",  4'd1,  8'h80, 8'h01, {8'h7F, 8'h00, 6'h12}, 1);
        test_directed("asr",  4'd10, 8'h80, 8'h03, {8'hF0, 8'h00, 6'h08}, 1);
        test_directed("mul",  4'd2,  8'hFF, 8'hFF, {8'h01, 8'hFE, 6'h11}, 9);
        test_directed("div",  4'd3,  8'h64, 8'h07, {8'h0E, 8'h02, 6'h10}, 9);
        test_directed("div0", 4'd3,  8'h35, 8'h00, {8'hFF, 8'h35, 6'h28}, 1);
        test_directed("op13", 4'd13, 8'h12, 8'h34, {8'h00, 8'h00, 6'h00}, 1);
    endtask

    task automatic test_backpressure;
        int lat;
        bit rs;
        exp_t e;
        run_op(4'd6, 8'h5A, 8'h0F, lat, rs);
        e = sb.pop_front();
        void'(lat_q.pop_front());
        checks++;
        if ({res, hi, flags} !== e || lat != 1) begin
            errors++;
            $display("FAIL bp_first: got %h lat %0d expected %h lat 1", {res, hi, flags}, lat, e);
        end
        @(negedge clk);
        in_valid = 1'b1; ctrl = 4'd0; a = 8'h01; b = 8'h02;
        sb.push_back(model(4'd0, 8'h01, 8'h02));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, in_ready, res, hi, flags} !== {2'b10, e}) begin
                errors++;
                $display("FAIL bp_hold%0d: got %h expected %h", i, {out_valid, in_ready, res, hi, flags}, {2'b10, e});
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_handshake: valid/ready got %b expected 01", {out_valid, in_ready});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if ({out_valid, res, hi, flags} !== {1'b1, e}) begin
            errors++;
            $display("FAIL bp_next: got %h expected %h", {out_valid, res, hi, flags}, {1'b1, e});
        end
        handshake();
    endtask

    task automatic test_reset_busy;
        int lat, el, seen;
        bit rs;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1; ctrl = 4'd2; a = 8'hFF; b = 8'hFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, res, hi, flags} !== 23'h0) begin
            errors++;
            $display("FAIL rst_busy_outputs: got %h expected 0", {out_valid, res, hi, flags});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_busy_ready: got %b expected 1", in_ready);
        end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_busy_stale: out_valid high %0d cycles expected 0", seen);
        end
        run_op(4'd0, 8'h03, 8'h04, lat, rs);
        e = sb.pop_front();
        el = lat_q.pop_front();
        checks++;
        if ({res, hi, flags} !== e || lat != el) begin
            errors++;
            $display("FAIL rst_busy_after: got %h lat %0d expected %h lat %0d", {res, hi, flags}, lat, e, el);
        end
        handshake();
    endtask

    task automatic test_back_to_back;
        int lat, el;
        bit rs;
        exp_t e;
        logic [3:0] op;
        logic [7:0] ra, rb;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 4) == 0) rb = 8'h00;
            run_op(op, ra, rb, lat, rs);
            e = sb.pop_front();
            el = lat_q.pop_front();
            checks++;
            if ({res, hi, flags} !== e || lat != el) begin
                errors++;
                $display("FAIL b2b_%0d op%0d a=%h b=%h: got %h lat %0d expected %h lat %0d",
                         i, op, ra, rb, {res, hi, flags}, lat, e, el);
            end
            handshake();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ops();
        test_backpressure();
        test_reset_busy();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning the operand and result width; legal values are 4 to 64.
REQ-002 The module SHALL have a derived localparam SHW = $clog2(WIDTH), meaning the width of the shift amount.
REQ-003 The module SHALL have port clk_in, input, 1 bit: the single clock, with all flops on the rising edge.
REQ-004 The module SHALL have port rst_n_in, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port in_valid_in, input, 1 bit: request valid.
REQ-006 The module SHALL have port in_ready_out, output, 1 bit: the block can accept a request.
REQ-007 The module SHALL have port a_in, input, WIDTH bits: operand A.
REQ-008 The module SHALL have port b_in, input, WIDTH bits: operand B, which also carries the shift amount in b_in[SHW-1:0].
REQ-009 The module SHALL have port ctrl_in, input, 4 bits: opcode.
REQ-010 The module SHALL have port out_valid_out, output, 1 bit: result valid.
REQ-011 The module SHALL have port out_ready_in, input, 1 bit: the consumer accepts the result.
REQ-012 The module SHALL have port results_out, output, WIDTH bits: primary result (MUL low half, DIV quotient).
REQ-013 The module SHALL have port results_hi_out, output, WIDTH bits: MUL high half, DIV remainder, 0 for all other ops.
REQ-014 The module SHALL have port flags_out, output, 6 bits: [0] C, [1] V, [2] Z, [3] N, [4] P, [5] DZ.

Function
REQ-015 The opcodes SHALL be: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 NOT(A), 8 SHL, 9 SHR, 10 ASR, 11 ROL, 12 ROR; opcodes 13-15 return 0 with all flags 0.
REQ-016 The FSM SHALL have states IDLE, BUSY and DONE; in_ready_out SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on a cycle where in_valid_in=1 and in_ready_out=1; a, b and ctrl SHALL then be registered, and later input changes SHALL be ignored.
REQ-018 Single-cycle ops (all except MUL/DIV) SHALL go IDLE->DONE, with out_valid_out=1 on the cycle after acceptance.
REQ-019 MUL and DIV SHALL go IDLE->BUSY for exactly WIDTH cycles, then DONE, so out_valid_out=1 on cycle WIDTH+1 after acceptance.
REQ-020 MUL SHALL be an unsigned shift-add multiply, with the 2*WIDTH product split into results_hi_out:results_out.
REQ-021 DIV SHALL be an unsigned restoring divide.
REQ-022 DIV with b=0 SHALL go directly to DONE in 1 cycle with quotient all-ones, remainder = a, and DZ=1.
REQ-023 In DONE, results_out, results_hi_out and flags_out SHALL stay stable until out_valid_out=1 and out_ready_in=1, after which the FSM returns to IDLE.
REQ-024 No new request SHALL be accepted in the same cycle as the result handshake; the earliest next acceptance is the following cycle.
REQ-025 ADD: C SHALL be the carry-out and V the signed overflow.
REQ-026 SUB: C SHALL be the borrow (a<b unsigned) and V the signed overflow.
REQ-027 MUL: C SHALL be 1 iff results_hi_out is not 0, with V=0.
REQ-028 Shifts: C SHALL be the last bit shifted out, or 0 when the amount is 0; V SHALL be 0.
REQ-029 Shift amount SHALL be b[SHW-1:0] only; the upper bits of b are ignored, and rotates wrap modulo WIDTH.
REQ-030 Logic ops SHALL set C=0 and V=0.
REQ-031 For all ops, Z SHALL be (results_out==0), N SHALL be the MSB of results_out, and P SHALL be the XOR-reduction of results_out.
REQ-032 DZ SHALL be 0 except for DIV with b=0.

Reset
REQ-033 While rst_n_in=0, the FSM SHALL be in IDLE and in_ready_out=1 (after release), with out_valid_out=0, results_out=0, results_hi_out=0, flags_out=0 and the iteration counter at 0.
REQ-034 Reset asserted mid-BUSY or mid-DONE SHALL abort the operation with no stale out_valid_out after release.

Structure
REQ-035 Package alu_mc_pkg SHALL hold the opcode enum, the FSM state enum and the flag bit-index constants.
REQ-036 Sub-module alu_mc_iter SHALL hold the iterative MUL/DIV datapath (accumulator, shift register, counter), with start/done handshake to the top-level FSM.
REQ-037 The single-cycle datapath and the flag generator SHALL be in the top level.

Verification (WIDTH=8)
REQ-038 The bench SHALL cover: ADD a=0xFF, b=0x01 -> results 0x00, C=1, Z=1, V=0, out_valid_out exactly 1 cycle after acceptance.
REQ-039 The bench SHALL cover: SUB a=0x80, b=0x01 -> results 0x7F, V=1, C=0, N=0; then ASR a=0x80, b=0x03 -> results 0xF0, N=1, C=0.
REQ-040 The bench SHALL cover: MUL a=0xFF, b=0xFF -> results_hi 0xFE, results 0x01, C=1, out_valid_out exactly 9 cycles after acceptance, in_ready_out=0 throughout.
REQ-041 The bench SHALL cover: DIV a=0x64, b=0x07 -> quotient 0x0E, remainder 0x02, DZ=0; and DIV a=0x35, b=0x00 -> results 0xFF, results_hi 0x35, DZ=1, 1-cycle latency.
REQ-042 The bench SHALL cover: out_ready_in held 0 for 5 cycles during DONE, with in_valid_in=1 and different operands -> outputs stable, request not accepted, accepted the cycle after the handshake.
REQ-043 The bench SHALL cover: rst_n_in pulsed low in the 4th BUSY cycle of a MUL -> all outputs 0 immediately, in_ready_out=1 after release, no out_valid_out until a new request.
